// File: rtl/seg7_pkg.sv
// Shared types and seven-segment encoding helpers for the BCD display path.
package seg7_pkg;

  // Frame accumulator control states
  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_CONV = 2'd1,
    ST_OUT  = 2'd2
  } acc_state_t;

  // Segment codes are gfedcba, active-high
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111   // 9
  };

  // Non-decimal nibbles should never reach the display; show a dash if they do
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] seg;
    if (d <= 4'd9) begin
      seg = SEG_DIGITS[d];
    end else begin
      seg = SEG_DASH;
    end
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle, SUMW steps total.
// The first step is folded into the start cycle so the result lands SUMW
// cycles after start. Bits shifted out of the top digit mean the value does
// not fit in D digits; they are kept in a sticky carry.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int SUMW = 11,
  parameter int D    = 3
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [SUMW-1:0]     bin,
  output logic                busy,
  output logic                done,
  output logic [D-1:0][3:0]   bcd,
  output logic                ovf
);

  localparam int CNTW = $clog2(SUMW + 1);

  logic [SUMW-1:0]   r_bin;
  logic [D-1:0][3:0] r_bcd;
  logic              r_carry;
  logic              r_busy;
  logic              r_done;
  logic [CNTW-1:0]   r_cnt;

  logic [SUMW-1:0]   w_src_bin;
  logic [D-1:0][3:0] w_src_bcd;
  logic [D-1:0][3:0] w_adj;
  logic [4*D-1:0]    w_flat;
  logic [D-1:0][3:0] w_next_bcd;
  logic [SUMW-1:0]   w_next_bin;
  logic              w_carry;

  // One double-dabble step from either the fresh operand or the running state
  always_comb begin
    w_src_bin = '0;
    w_src_bcd = '0;
    if (start) begin
      w_src_bin = bin;
      w_src_bcd = '0;
    end else begin
      w_src_bin = r_bin;
      w_src_bcd = r_bcd;
    end
    for (int i = 0; i < D; i++) begin
      if (w_src_bcd[i] >= 4'd5) begin
        w_adj[i] = w_src_bcd[i] + 4'd3;
      end else begin
        w_adj[i] = w_src_bcd[i];
      end
    end
    w_flat     = w_adj;
    w_carry    = w_flat[4*D-1];
    w_next_bcd = {w_flat[4*D-2:0], w_src_bin[SUMW-1]};
    w_next_bin = {w_src_bin[SUMW-2:0], 1'b0};
  end

  // Step sequencing, sticky overflow and the one-cycle done pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bin   <= '0;
      r_bcd   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_bin   <= w_next_bin;
        r_bcd   <= w_next_bcd;
        r_carry <= w_carry;
        r_cnt   <= CNTW'(SUMW - 1);
        r_busy  <= 1'b1;
      end else if (r_busy) begin
        r_bin   <= w_next_bin;
        r_bcd   <= w_next_bcd;
        r_carry <= r_carry | w_carry;
        r_cnt   <= r_cnt - 1'b1;
        if (r_cnt == CNTW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_busy <= 1'b1;
        end
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign ovf  = r_carry | (r_bcd[D-1] > 4'd9);

endmodule

// File: rtl/axis_accum_bcd.sv
// AXI-Stream frame accumulator: sums up to N beats (or until s_last), converts
// the sum to D BCD digits and holds the seven-segment codes on the master port
// until accepted.
module axis_accum_bcd
  import seg7_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 5,
  parameter int D     = 3,
  parameter bit BLANK = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [W-1:0]            s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [D-1:0][6:0]       m_data,
  output logic                    m_ovf,
  output logic [$clog2(N+1)-1:0]  m_count
);

  localparam int SUMW = W + $clog2(N + 1);
  localparam int CW   = $clog2(N + 1);

  acc_state_t        r_state;
  logic [SUMW-1:0]   r_sum;
  logic [CW-1:0]     r_cnt;
  logic              r_start;
  logic [D-1:0][6:0] r_m_data;
  logic              r_m_ovf;
  logic [CW-1:0]     r_m_count;

  logic              w_busy;
  logic              w_done;
  logic [D-1:0][3:0] w_bcd;
  logic              w_ovf;
  logic [SUMW-1:0]   w_sum_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_close;
  logic              w_accept;
  logic [D-1:0][6:0] w_seg;
  logic              w_lead;

  bin2bcd_seq #(
    .SUMW (SUMW),
    .D    (D)
  ) u_bin2bcd (
    .clk   (clk),
    .rstn  (rstn),
    .start (r_start),
    .bin   (r_sum),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd),
    .ovf   (w_ovf)
  );

  // Next accumulator values and frame-close detection for the current beat
  always_comb begin
    w_accept  = s_valid && (r_state == ST_ACC);
    w_sum_nxt = r_sum + {{(SUMW-W){1'b0}}, s_data};
    w_cnt_nxt = r_cnt + 1'b1;
    w_close   = (r_cnt == CW'(N - 1)) || s_last;
  end

  // Segment encoding with dash-on-overflow and leading-zero blanking
  always_comb begin
    w_seg  = '0;
    w_lead = 1'b1;
    for (int i = D - 1; i >= 0; i--) begin
      if (w_ovf) begin
        w_seg[i] = SEG_DASH;
      end else if (BLANK && w_lead && (i != 0) && (w_bcd[i] == 4'd0)) begin
        w_seg[i] = SEG_BLANK;
      end else begin
        w_seg[i] = bcd_to_seg(w_bcd[i]);
      end
      if (w_bcd[i] != 4'd0) begin
        w_lead = 1'b0;
      end else begin
        w_lead = w_lead;
      end
    end
  end

  // Frame FSM: accumulate, convert, then hold the result until accepted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_ACC;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_m_data  <= '0;
      r_m_ovf   <= 1'b0;
      r_m_count <= '0;
    end else begin
      case (r_state)
        ST_ACC: begin
          if (w_accept) begin
            r_sum <= w_sum_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_close) begin
              r_state <= ST_CONV;
              r_start <= 1'b1;
            end
          end
        end
        ST_CONV: begin
          r_start <= 1'b0;
          if (w_done) begin
            r_m_data  <= w_seg;
            r_m_ovf   <= w_ovf;
            r_m_count <= r_cnt;
            r_state   <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            r_state <= ST_ACC;
            r_sum   <= '0;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_ACC;
          r_sum   <= '0;
          r_cnt   <= '0;
          r_start <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = (r_state == ST_ACC);
  assign m_valid = (r_state == ST_OUT);
  assign m_data  = r_m_data;
  assign m_ovf   = r_m_ovf;
  assign m_count = r_m_count;

endmodule
